key_conditioner: RTL and testbench
==================================

# key_conditioner

Input-conditioning stage directly upstream of the vending-machine core. Takes the raw board pushbuttons (cancel, confirm, done; active-low) and the two 3-bit selection switch banks (product kind, coin/change). Synchronises and debounces every input. Delivers single-cycle press pulses for the buttons and glitch-free levels for the switches, ready to wire straight onto the core's `cancel_i`/`sure_i`/`done_i`/`kind_i`/`change_i` inputs.

## Interface
- `DEB_CYCLES`, default 1000000: consecutive stable cycles required to accept a new level (20 ms at 50 MHz); must be ≥ 1.
- `REPEAT_CYCLES`, default 12500000: auto-repeat interval; used only when the repeat feature is compiled in.
- `clk_i`  in  1  system clock; single clock domain.
- `n_reset_i`  in  1  reset, asynchronous assert, active-low.
- `key_n_i`  in  3  raw buttons, active-low, asynchronous to `clk_i`; bit 0 = cancel, bit 1 = confirm, bit 2 = done.
- `kind_sw_i`  in  3  raw product-kind switches, asynchronous.
- `change_sw_i`  in  3  raw coin/change switches, asynchronous.
- `cancel_o`, `sure_o`, `done_o`  out  1 each  one-cycle pulse per accepted press.
- `key_held_o`  out  3  debounced pressed level per button, active-high.
- `kind_o`  out  3  debounced `kind_sw_i`.
- `change_o`  out  3  debounced `change_sw_i`.

## Operation
- Conditioning path for each of the 9 input bits:
  - 2-flop synchroniser.
  - Debounce cell holding an accepted stable level and a counter of width clog2(`DEB_CYCLES`+1).
- Debounce cell FSM has four states:
  - STABLE_LO: synchronised sample = 1 → go to WAIT_HI, counter := 1.
  - WAIT_HI:
    - sample = 0 → back to STABLE_LO, counter := 0.
    - sample = 1 and counter = `DEB_CYCLES` → go to STABLE_HI, flip the accepted level, counter := 0.
    - otherwise → counter += 1.
  - STABLE_HI and WAIT_LO: mirror images of the two states above.
- Bounce handling: any sample that differs from the pending target aborts the wait and returns to the previous stable state. There is no partial credit.
- Buttons are inverted after synchronisation, so internal level 1 = pressed.
- Press pulse:
  - A press pulse is emitted on the accepted 0→1 transition of the pressed level only.
  - Release emits nothing.
  - Each pulse output is registered and high for exactly one cycle.
- Buttons are independent. Simultaneous accepted presses produce simultaneous pulses; no arbitration happens here.
- Switch banks: each bit is debounced independently, and `kind_o`/`change_o` are the accepted levels. Multi-bit coherence is not guaranteed during transitions.
- Reset values:
  - Synchronisers: button bits hold 1 (released); switch bits hold 0.
  - Debounce cells: button cells start in STABLE_LO (not pressed); switch cells start in STABLE_LO.
  - All counters = 0.
  - `cancel_o`/`sure_o`/`done_o` = 0, `key_held_o` = 0, `kind_o` = 0, `change_o` = 0.
- A switch that is already high at reset release is accepted after the normal debounce latency.
- A button held through reset release produces one press pulse after the normal debounce latency.
- Reset asserted mid-wait discards the pending transition with no pulse.

## Timing
- Latency is measured from the first `clk_i` edge at which the raw pin shows a stable new level:
  - Accepted level changes after 2 (synchroniser) + `DEB_CYCLES` cycles.
  - The pulse is high during the following cycle, i.e. visible on the output at edge 2 + `DEB_CYCLES` + 1.
  - Pulse and `key_held_o` rise on the same edge.
- A glitch shorter than `DEB_CYCLES` cycles at the synchroniser output never changes any output.
- Minimum pulse spacing for one button = 2·(`DEB_CYCLES`+1) cycles (press + release + press).
- Counter never wraps: it saturates at `DEB_CYCLES` by construction, because the state changes on reaching it.

## Configuration
- `KEY_AUTOREPEAT_EN` defined:
  - While a button stays in STABLE_HI, a per-button repeat counter runs.
  - After `REPEAT_CYCLES` cycles it emits one extra pulse on that button's output and restarts.
  - This gives one pulse per `REPEAT_CYCLES` for as long as the button is held.
  - Release, or entry to WAIT_LO, clears the counter immediately.
  - Reset value of the counter is 0.
- Not defined: no repeat counters are built, and exactly one pulse is emitted per press regardless of hold time.
- The switch path is unaffected in both cases.

## Structure
- Shared package `vend_pkg` holds:
  - Debounce state enumeration (STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO).
  - Button index constants KEY_CANCEL = 0, KEY_SURE = 1, KEY_DONE = 2.
  - Default `DEB_CYCLES`/`REPEAT_CYCLES` constants.
- One sub-module `debounce_cell`: synchroniser, FSM, counter and a registered rise-pulse output, parameterised by `DEB_CYCLES` and by reset level.
- The block instantiates 9 cells; it adds the button inversion and, under the macro, the repeat counters.

## Test plan
Benches use `DEB_CYCLES` = 4 and `REPEAT_CYCLES` = 10.
- Reset check: assert `n_reset_i` = 0 with `key_n_i` = 3'b111 and switches = 0, then release. All outputs stay 0 for 20 cycles.
- Clean press: drive `key_n_i`[1] low at cycle 0 and hold it.
  - `sure_o` is 1 only in cycle 7; `key_held_o`[1] goes 1 from cycle 7.
  - Releasing at cycle 20 clears `key_held_o`[1] at cycle 27 with no pulse.
- Bounce: toggle `key_n_i`[0] low/high every 2 cycles for 12 cycles, then hold it low. Exactly one `cancel_o` pulse, 7 cycles after the final stable low.
- Glitch rejection: `kind_sw_i` = 3'b101 for 3 cycles, then back to 0. `kind_o` stays 0.
  - The same value held for 10 cycles gives `kind_o` = 3'b101 from cycle 6.
- Simultaneous presses and reset abort:
  - Press all three buttons on the same cycle: `cancel_o`, `sure_o` and `done_o` pulse on the same cycle.
  - Assert reset during a WAIT_HI: no pulse.
- Repeat, with `KEY_AUTOREPEAT_EN`: hold `key_n_i`[2] low for 40 cycles. `done_o` pulses at cycles 7, 17, 27, 37 and stops on release.
  - Without the macro there is a single pulse at cycle 7.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared definitions for the vending-machine input path: debounce states,
// button indices and default timing constants.
package vend_pkg;

   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      WAIT_HI   = 2'd1,
      STABLE_HI = 2'd2,
      WAIT_LO   = 2'd3
   } deb_state_t;

   localparam int KEY_CANCEL = 0;
   localparam int KEY_SURE   = 1;
   localparam int KEY_DONE   = 2;
   localparam int NUM_KEYS   = 3;
   localparam int SW_BITS    = 3;

   localparam int DEB_CYCLES_DEF    = 1000000;
   localparam int REPEAT_CYCLES_DEF = 12500000;

endpackage

// File: rtl/debounce_cell.sv
// One conditioned input bit: 2-flop synchroniser, four-state debounce FSM with
// a stability counter, and a registered pulse on each accepted rise.
module debounce_cell
   import vend_pkg::*;
#(
   parameter int   DEB_CYCLES = DEB_CYCLES_DEF,
   parameter logic RST_LEVEL  = 1'b0,
   parameter logic INVERT     = 1'b0
) (
   input  logic clk,
   input  logic n_reset,
   input  logic raw,
   output logic level,
   output logic held,
   output logic rise,
   output logic stable_hi
);

   localparam int             CW      = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0]  CNT_MAX = CW'(DEB_CYCLES);

   logic          sync1_reg;
   logic          sync2_reg;
   logic          sample;
   deb_state_t    state_reg;
   deb_state_t    state_next;
   logic [CW-1:0] cnt_reg;
   logic [CW-1:0] cnt_next;
   logic          level_reg;
   logic          level_next;
   logic          held_reg;
   logic          rise_reg;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         sync1_reg <= RST_LEVEL;
         sync2_reg <= RST_LEVEL;
      end else begin
         sync1_reg <= raw;
         sync2_reg <= sync1_reg;
      end
   end

   assign sample = sync2_reg ^ INVERT;

   // Any sample disagreeing with the pending target drops straight back to
   // the previous stable state and the count starts over from scratch.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      level_next = level_reg;
      case (state_reg)
         STABLE_LO: begin
            if (sample) begin
               state_next = WAIT_HI;
               cnt_next   = CW'(1);
            end
         end
         WAIT_HI: begin
            if (!sample) begin
               state_next = STABLE_LO;
               cnt_next   = '0;
            end else if (cnt_reg == CNT_MAX) begin
               state_next = STABLE_HI;
               level_next = 1'b1;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         STABLE_HI: begin
            if (!sample) begin
               state_next = WAIT_LO;
               cnt_next   = CW'(1);
            end
         end
         WAIT_LO: begin
            if (sample) begin
               state_next = STABLE_HI;
               cnt_next   = '0;
            end else if (cnt_reg == CNT_MAX) begin
               state_next = STABLE_LO;
               level_next = 1'b0;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         default: begin
            state_next = STABLE_LO;
            cnt_next   = '0;
            level_next = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_reg <= STABLE_LO;
         cnt_reg   <= '0;
         level_reg <= 1'b0;
         held_reg  <= 1'b0;
         rise_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         level_reg <= level_next;
         // Delayed copy keeps the held level aligned with the rise pulse.
         held_reg  <= level_reg;
         rise_reg  <= level_reg & ~held_reg;
      end
   end

   assign level     = level_reg;
   assign held      = held_reg;
   assign rise      = rise_reg;
   assign stable_hi = (state_reg == STABLE_HI);

endmodule

// File: rtl/key_conditioner.sv
// Conditions the three active-low buttons and two switch banks for the vending
// core. Define KEY_AUTOREPEAT_EN to build per-button auto-repeat while held.
module key_conditioner
   import vend_pkg::*;
#(
   parameter int DEB_CYCLES    = DEB_CYCLES_DEF,
   parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
   input  logic                clk_i,
   input  logic                n_reset_i,
   input  logic [NUM_KEYS-1:0] key_n_i,
   input  logic [SW_BITS-1:0]  kind_sw_i,
   input  logic [SW_BITS-1:0]  change_sw_i,
   output logic                cancel_o,
   output logic                sure_o,
   output logic                done_o,
   output logic [NUM_KEYS-1:0] key_held_o,
   output logic [SW_BITS-1:0]  kind_o,
   output logic [SW_BITS-1:0]  change_o
);

   logic [NUM_KEYS-1:0]  key_level;
   logic [NUM_KEYS-1:0]  key_held;
   logic [NUM_KEYS-1:0]  key_rise;
   logic [NUM_KEYS-1:0]  key_stable_hi;
   logic [NUM_KEYS-1:0]  key_pulse;

   logic [2*SW_BITS-1:0] sw_raw;
   logic [2*SW_BITS-1:0] sw_level;
   logic [2*SW_BITS-1:0] sw_held;
   logic [2*SW_BITS-1:0] sw_rise;
   logic [2*SW_BITS-1:0] sw_stable_hi;

   logic                 unused_bits;

   genvar gi;

   // Button pins idle high; the cell inverts so level 1 means pressed.
   generate
      for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
         debounce_cell #(
            .DEB_CYCLES (DEB_CYCLES),
            .RST_LEVEL  (1'b1),
            .INVERT     (1'b1)
         ) u_cell (
            .clk       (clk_i),
            .n_reset   (n_reset_i),
            .raw       (key_n_i[gi]),
            .level     (key_level[gi]),
            .held      (key_held[gi]),
            .rise      (key_rise[gi]),
            .stable_hi (key_stable_hi[gi])
         );

`ifdef KEY_AUTOREPEAT_EN
         localparam int RW = $clog2(REPEAT_CYCLES + 1);

         logic [RW-1:0] rpt_reg;
         logic          rpt_pulse_reg;

         // Counting starts once the press pulse has gone out, so repeats
         // land a whole REPEAT_CYCLES after it and after each other.
         always_ff @(posedge clk_i or negedge n_reset_i) begin
            if (!n_reset_i) begin
               rpt_reg       <= '0;
               rpt_pulse_reg <= 1'b0;
            end else begin
               rpt_pulse_reg <= 1'b0;
               if (!(key_stable_hi[gi] && key_held[gi])) begin
                  rpt_reg <= '0;
               end else if (rpt_reg == RW'(REPEAT_CYCLES - 1)) begin
                  rpt_reg       <= '0;
                  rpt_pulse_reg <= 1'b1;
               end else begin
                  rpt_reg <= rpt_reg + RW'(1);
               end
            end
         end

         assign key_pulse[gi] = key_rise[gi] | rpt_pulse_reg;
`else
         assign key_pulse[gi] = key_rise[gi];
`endif
      end
   endgenerate

   assign sw_raw = {change_sw_i, kind_sw_i};

   generate
      for (gi = 0; gi < 2 * SW_BITS; gi++) begin : g_sw
         debounce_cell #(
            .DEB_CYCLES (DEB_CYCLES),
            .RST_LEVEL  (1'b0),
            .INVERT     (1'b0)
         ) u_cell (
            .clk       (clk_i),
            .n_reset   (n_reset_i),
            .raw       (sw_raw[gi]),
            .level     (sw_level[gi]),
            .held      (sw_held[gi]),
            .rise      (sw_rise[gi]),
            .stable_hi (sw_stable_hi[gi])
         );
      end
   endgenerate

`ifdef KEY_AUTOREPEAT_EN
   assign unused_bits = ^{key_level, sw_held, sw_rise, sw_stable_hi};
`else
   localparam int unused_repeat_cycles = REPEAT_CYCLES;
   assign unused_bits = ^{key_level, key_stable_hi, sw_held, sw_rise, sw_stable_hi};
`endif

   assign cancel_o   = key_pulse[KEY_CANCEL];
   assign sure_o     = key_pulse[KEY_SURE];
   assign done_o     = key_pulse[KEY_DONE];
   assign key_held_o = key_held;
   assign kind_o     = sw_level[SW_BITS-1:0];
   assign change_o   = sw_level[2*SW_BITS-1:SW_BITS];

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner with DEB_CYCLES=4, REPEAT_CYCLES=10;
// expected output vectors are queued per cycle as each stimulus phase starts.
module tb_key_conditioner;
   import vend_pkg::*;

   localparam int DEB = 4;
   localparam int REP = 10;
`ifdef KEY_AUTOREPEAT_EN
   localparam bit REP_ON = 1'b1;
`else
   localparam bit REP_ON = 1'b0;
`endif

   logic       clk;
   logic       n_reset;
   logic [2:0] key_n;
   logic [2:0] kind_sw;
   logic [2:0] change_sw;
   logic       cancel;
   logic       sure;
   logic       done;
   logic [2:0] key_held;
   logic [2:0] kind;
   logic [2:0] change;

   key_conditioner #(
      .DEB_CYCLES    (DEB),
      .REPEAT_CYCLES (REP)
   ) dut (
      .clk_i       (clk),
      .n_reset_i   (n_reset),
      .key_n_i     (key_n),
      .kind_sw_i   (kind_sw),
      .change_sw_i (change_sw),
      .cancel_o    (cancel),
      .sure_o      (sure),
      .done_o      (done),
      .key_held_o  (key_held),
      .kind_o      (kind),
      .change_o    (change)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int gcyc = 0;
   always @(posedge clk) gcyc <= gcyc + 1;

   typedef struct {
      int          at;
      int          k;
      string       tag;
      logic [11:0] vec;
   } sb_t;

   sb_t sb_q[$];
   sb_t mon_ent;
   int  n_checks = 0;
   int  n_fail   = 0;
   int  base;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Vector layout: {cancel, sure, done, held[2:0], kind[2:0], change[2:0]}
   function automatic logic [11:0] mk(input logic c, input logic s, input logic d,
                                      input logic [2:0] h, input logic [2:0] kd,
                                      input logic [2:0] ch);
      return {c, s, d, h, kd, ch};
   endfunction

   // Press pulse at rise; with auto-repeat, further pulses every REP cycles
   // until the release reaches the FSM two cycles after the pin.
   function automatic logic exp_pulse(input int k, input int rise, input int rel);
      if (k == rise) return 1'b1;
      if (REP_ON && k > rise && k <= rel + 2 && ((k - rise) % REP) == 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic push_exp(input string tag, input int b, input int k, input logic [11:0] v);
      sb_t e;
      e.at  = b + 1 + k;
      e.k   = k;
      e.tag = tag;
      e.vec = v;
      sb_q.push_back(e);
   endtask

   always @(negedge clk) begin
      while (sb_q.size() > 0 && sb_q[0].at <= gcyc) begin
         mon_ent = sb_q.pop_front();
         if (mon_ent.at < gcyc)
            check_eq({mon_ent.tag, "_missed"}, mon_ent.at, gcyc);
         else
            check_eq($sformatf("%s@%0d", mon_ent.tag, mon_ent.k),
                     {cancel, sure, done, key_held, kind, change}, mon_ent.vec);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected end of stimulus");
      $fatal(1, "watchdog expired");
   end

   initial begin
      key_n     = 3'b111;
      kind_sw   = 3'b000;
      change_sw = 3'b000;
      n_reset   = 1'b0;

      // Reset state, checked while asserted and for 20 cycles after release
      tick(1);
      base = gcyc;
      push_exp("rst_hold", base, 0, 12'h000);
      tick(3);
      n_reset = 1'b1;
      base = gcyc;
      $display("phase reset: release, outputs idle for 20 cycles");
      for (int k = 0; k < 20; k++) push_exp("rst", base, k, 12'h000);
      tick(20);

      // Clean press of confirm, released at cycle 20
      base = gcyc;
      $display("phase press: key_n[1] low cycles 0..19");
      key_n[KEY_SURE] = 1'b0;
      for (int k = 0; k < 40; k++)
         push_exp("press", base, k,
                  mk(1'b0, exp_pulse(k, 7, 20), 1'b0, {1'b0, (k >= 7 && k < 27), 1'b0}, 3'b000, 3'b000));
      tick(20);
      key_n[KEY_SURE] = 1'b1;
      tick(20);

      // Bouncing cancel, stable low from cycle 12, released at cycle 30
      base = gcyc;
      $display("phase bounce: key_n[0] toggles 12 cycles then low");
      for (int k = 0; k < 50; k++)
         push_exp("bounce", base, k,
                  mk(exp_pulse(k, 19, 30), 1'b0, 1'b0, {2'b00, (k >= 19 && k < 37)}, 3'b000, 3'b000));
      for (int i = 0; i < 3; i++) begin
         key_n[KEY_CANCEL] = 1'b0;
         tick(2);
         key_n[KEY_CANCEL] = 1'b1;
         tick(2);
      end
      key_n[KEY_CANCEL] = 1'b0;
      tick(18);
      key_n[KEY_CANCEL] = 1'b1;
      tick(20);

      // Short switch glitch is rejected
      base = gcyc;
      $display("phase glitch: kind_sw=101 for 3 cycles");
      for (int k = 0; k < 15; k++) push_exp("glitch", base, k, 12'h000);
      kind_sw = 3'b101;
      tick(3);
      kind_sw = 3'b000;
      tick(12);

      // Switch banks held 10 cycles
      base = gcyc;
      $display("phase switch: kind_sw=101 change_sw=110 for 10 cycles");
      for (int k = 0; k < 25; k++)
         push_exp("switch", base, k,
                  mk(1'b0, 1'b0, 1'b0, 3'b000,
                     (k >= 6 && k < 16) ? 3'b101 : 3'b000,
                     (k >= 6 && k < 16) ? 3'b110 : 3'b000));
      kind_sw   = 3'b101;
      change_sw = 3'b110;
      tick(10);
      kind_sw   = 3'b000;
      change_sw = 3'b000;
      tick(15);

      // All three buttons together, released at cycle 12
      base = gcyc;
      $display("phase simul: all keys low cycles 0..11");
      for (int k = 0; k < 30; k++)
         push_exp("simul", base, k,
                  mk(exp_pulse(k, 7, 12), exp_pulse(k, 7, 12), exp_pulse(k, 7, 12),
                     (k >= 7 && k < 19) ? 3'b111 : 3'b000, 3'b000, 3'b000));
      key_n = 3'b000;
      tick(12);
      key_n = 3'b111;
      tick(18);

      // Reset during WAIT_HI discards the pending press
      base = gcyc;
      $display("phase abort: done pressed, reset at cycle 4");
      for (int k = 0; k < 20; k++) push_exp("abort", base, k, 12'h000);
      key_n[KEY_DONE] = 1'b0;
      tick(4);
      n_reset = 1'b0;
      tick(2);
      key_n = 3'b111;
      tick(1);
      n_reset = 1'b1;
      tick(13);

      // Done held through reset release, kept 40 cycles (repeat check)
      $display("phase hold: done held through reset, 40 cycles");
      n_reset = 1'b0;
      key_n[KEY_DONE] = 1'b0;
      tick(3);
      n_reset = 1'b1;
      base = gcyc;
      for (int k = 0; k < 60; k++)
         push_exp("hold", base, k,
                  mk(1'b0, 1'b0, exp_pulse(k, 7, 40), {(k >= 7 && k < 47), 2'b00}, 3'b000, 3'b000));
      tick(40);
      key_n = 3'b111;
      tick(20);

      tick(2);
      check_eq("sb_drain", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
